pll_lock_rst_ctrl: RTL and testbench
====================================

// Module: pll_lock_rst_ctrl
// PURPOSE
//  Consumer end of the PLL lock interface. Drives the PLL RST pin, watches the asynchronous
//  pll_lock, and releases a system reset only after lock has been stable. Re-resets the PLL on
//  lock loss or lock timeout, gives up after RETRY_MAX attempts, and reports counts/status.
//  Runs on the free-running 50 MHz board clock, not on any PLL output.
// PARAMETERS
//  PLL_RST_CYCLES  16      pll_rst pulse width, cycles (>=1)
//  LOCK_TIMEOUT    100000  max cycles from pll_rst release to RUN (2 ms @ 50 MHz)
//  STABLE_CYCLES   1024    consecutive synced-high lock samples required before RUN (>=1)
//  RETRY_MAX       7       failed attempts before FAIL; 0 = retry forever; max 15
//  CNT_W           8       width of loss_cnt
// PORTS
//  sys_clk     in   1      50 MHz free-running clock
//  sys_rst_n   in   1      async assert, active-low reset
//  pll_lock    in   1      PLL LOCK, asynchronous to sys_clk
//  retry_req   in   1      1-cycle pulse; restarts from FAIL, ignored elsewhere
//  pll_rst     out  1      to PLL RST, active-high
//  rst_out_n   out  1      downstream reset, active-low, sys_clk synchronous
//  locked      out  1      1 only in RUN
//  fail        out  1      1 only in FAIL
//  retry_cnt   out  4      failed attempts since last RUN or retry_req
//  loss_cnt    out  CNT_W  lock losses seen in RUN, saturating at all-ones
//  state       out  3      current FSM state encoding
// BEHAVIOUR
//  - Reset (sys_rst_n=0, async): state=PLL_RST, pll_rst=1, rst_out_n=0, locked=0, fail=0,
//    retry_cnt=0, loss_cnt=0, all timers 0, synchroniser flops 0.
//  - pll_lock passes a 2-flop synchroniser -> lock_s; 2-cycle latency. FSM uses lock_s only.
//  - All outputs are registered and change on the edge that enters the new state.
//  - PLL_RST(0): pll_rst=1 for exactly PLL_RST_CYCLES cycles, then -> WAIT_LOCK; the timeout
//    timer clears on exit.
//  - WAIT_LOCK(1): timeout timer counts up. lock_s=1 -> STABLE (stable counter = 1).
//    Timer reaches LOCK_TIMEOUT -> attempt failed.
//  - STABLE(2): stable counter counts consecutive lock_s=1. Reaching STABLE_CYCLES -> RUN.
//    lock_s=0 -> WAIT_LOCK; stable counter clears, timeout timer keeps running.
//    Timeout -> attempt failed.
//  - Simultaneous events: lock_s=1 beats timeout in WAIT_LOCK, and stable-complete beats
//    timeout in STABLE.
//  - Attempt failed: retry_cnt+1. If RETRY_MAX!=0 and the new value == RETRY_MAX -> FAIL,
//    otherwise -> PLL_RST. At RETRY_MAX=0, retry_cnt saturates at 15.
//  - RUN(3): rst_out_n=1, locked=1, retry_cnt cleared on entry. lock_s=0 -> loss_cnt+1
//    (saturating) and -> PLL_RST. rst_out_n=0 and locked=0 on that same edge.
//  - FAIL(4): pll_rst=0, rst_out_n=0, fail=1. retry_req=1 -> retry_cnt=0 and -> PLL_RST.
//    pll_lock going high in FAIL has no effect.
//  - loss_cnt clears only on sys_rst_n.
//  - sys_rst_n asserted mid-operation: immediate return to reset values, so rst_out_n drops
//    asynchronously. Deassertion restarts at PLL_RST.
//  - Timers are sized by $clog2 of their parameter + 1; no wrap is possible before compare.
// STRUCTURE
//  - pll_rst_pkg: state localparams ST_PLL_RST=3'd0, ST_WAIT_LOCK=3'd1, ST_STABLE=3'd2,
//    ST_RUN=3'd3, ST_FAIL=3'd4, plus the parameter defaults.
//  - Sub-module sync_2ff (1-bit, async-reset-to-0 synchroniser) for pll_lock; reusable for
//    other CDC bits.
//  - FSM, timers and counters live in this module.
// TESTING  (bench params: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, RETRY_MAX=3)
//  1 Nominal: release reset, raise pll_lock 20 cycles after pll_rst falls
//    -> pll_rst=1 for exactly 4 cycles; rst_out_n=1, locked=1 exactly 2+8 cycles after the
//    pll_lock rise (+1 edge); retry_cnt=0.
//  2 Glitch: in STABLE, drop pll_lock for 1 cycle at sample 5
//    -> stable count restarts, no pll_rst pulse, RUN reached 8 samples after re-rise.
//  3 Timeout/FAIL: hold pll_lock=0
//    -> three 4-cycle pll_rst pulses spaced 100 cycles apart; retry_cnt 1,2,3; fail=1,
//    state=4, pll_rst=0.
//    Then pulse retry_req -> retry_cnt=0, new pll_rst pulse.
//  4 Lock loss in RUN: drop pll_lock
//    -> rst_out_n=0 2+1 cycles later, loss_cnt=1, pll_rst pulse, RUN regained.
//    Repeat 260x with CNT_W=8 -> loss_cnt saturates at 255.
//  5 Corners: lock_s rises on the same cycle the timer hits 100 -> goes to STABLE, no retry.
//    Stable completes on the timeout cycle -> RUN.
//    retry_req in RUN -> ignored.
//  6 Async reset in RUN mid-cycle -> rst_out_n=0 and pll_rst=1 before the next edge; all
//    counters 0.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// ----------------------------------------------------------------------------
// pll_rst_pkg
// Shared definitions for the PLL lock / reset controller:
//   - 3-bit state encodings exposed on the controller's state output
//   - typed FSM state enum built on those encodings
//   - default values for the controller parameters
//   - small saturating-increment helper for the status counters
// ----------------------------------------------------------------------------
package pll_rst_pkg;

    // State encodings; these values are visible on the state output port.
    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    typedef enum logic [2:0] {
        StPllRst   = ST_PLL_RST,
        StWaitLock = ST_WAIT_LOCK,
        StStable   = ST_STABLE,
        StRun      = ST_RUN,
        StFail     = ST_FAIL
    } pll_state_e;

    // Parameter defaults (50 MHz board clock).
    localparam int unsigned PLL_RST_CYCLES_DEF = 16;
    localparam int unsigned LOCK_TIMEOUT_DEF   = 100000;  // 2 ms
    localparam int unsigned STABLE_CYCLES_DEF  = 1024;
    localparam int unsigned RETRY_MAX_DEF      = 7;
    localparam int unsigned CNT_W_DEF          = 8;

    // retry_cnt is fixed at 4 bits, so it saturates at 15.
    localparam logic [3:0] RETRY_CNT_MAX = 4'hF;

    // Saturating +1 for the 4-bit retry counter.
    function automatic logic [3:0] retry_sat_inc(input logic [3:0] val);
        return (val == RETRY_CNT_MAX) ? val : val + 4'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit. Both flops reset to 0.
// Output follows the input with two destination-clock edges of latency.
// Ports:
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset
//   d      in  asynchronous input bit
//   q      out synchronised bit
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_rst_ctrl.sv
// ----------------------------------------------------------------------------
// pll_lock_rst_ctrl
// Consumer end of the PLL lock interface. Pulses the PLL reset pin, waits for
// a synchronised lock indication to stay high for STABLE_CYCLES samples, then
// releases the downstream reset. Lock loss or lock timeout re-resets the PLL;
// after RETRY_MAX failed attempts the block parks in FAIL until retry_req.
// Runs on the free-running board clock, never on a PLL output.
// Ports:
//   sys_clk    in   free-running board clock
//   sys_rst_n  in   asynchronous active-low reset
//   pll_lock   in   PLL lock, asynchronous to sys_clk
//   retry_req  in   1-cycle pulse, restarts from FAIL (ignored elsewhere)
//   pll_rst    out  PLL reset, active-high
//   rst_out_n  out  downstream reset, active-low
//   locked     out  high only in RUN
//   fail       out  high only in FAIL
//   retry_cnt  out  failed attempts since last RUN or retry_req (sat. 15)
//   loss_cnt   out  lock losses seen in RUN, saturating
//   state      out  current FSM state encoding
// ----------------------------------------------------------------------------
module pll_lock_rst_ctrl
    import pll_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
    parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF,
    parameter int unsigned RETRY_MAX      = RETRY_MAX_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pll_lock,
    input  logic             retry_req,
    output logic             pll_rst,
    output logic             rst_out_n,
    output logic             locked,
    output logic             fail,
    output logic [3:0]       retry_cnt,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [2:0]       state
);

    // One spare bit on each timer so the +1 value never wraps before compare.
    localparam int unsigned RST_W  = $clog2(PLL_RST_CYCLES) + 1;
    localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES) + 1;

    pll_state_e        st_q;
    logic              pll_rst_q;
    logic              rst_out_n_q;
    logic              locked_q;
    logic              fail_q;
    logic [3:0]        retry_cnt_q;
    logic [CNT_W-1:0]  loss_cnt_q;
    logic [RST_W-1:0]  rst_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [STAB_W-1:0] stab_cnt_q;

    logic              lock_s;

    logic              rst_done;
    logic [TO_W-1:0]   to_inc;
    logic              timeout;
    logic [STAB_W-1:0] stab_inc;
    logic              stab_done;
    logic [3:0]        retry_inc;
    logic              give_up;
    logic [CNT_W-1:0]  loss_inc;

    // ------------------------------------------------------------------
    // Lock synchroniser; the FSM only ever looks at lock_s.
    // ------------------------------------------------------------------
    sync_2ff u_lock_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // ------------------------------------------------------------------
    // Timer / counter decode
    // ------------------------------------------------------------------
    always_comb begin
        rst_done  = (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1));
        to_inc    = to_cnt_q + TO_W'(1);
        // ">=" so a lock-won timeout cycle still times out on the next STABLE cycle.
        timeout   = (to_inc >= TO_W'(LOCK_TIMEOUT));
        stab_inc  = stab_cnt_q + STAB_W'(1);
        stab_done = (stab_inc >= STAB_W'(STABLE_CYCLES));
        retry_inc = retry_sat_inc(retry_cnt_q);
        give_up   = (RETRY_MAX != 0) && (retry_inc == 4'(RETRY_MAX));
        loss_inc  = (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + CNT_W'(1);
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs; every output changes on the edge that
    // enters the new state.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_q        <= StPllRst;
            pll_rst_q   <= 1'b1;
            rst_out_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            retry_cnt_q <= 4'd0;
            loss_cnt_q  <= '0;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            stab_cnt_q  <= '0;
        end else begin
            unique case (st_q)
                StPllRst: begin
                    if (rst_done) begin
                        st_q      <= StWaitLock;
                        pll_rst_q <= 1'b0;
                        rst_cnt_q <= '0;
                        to_cnt_q  <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RST_W'(1);
                    end
                end

                StWaitLock: begin
                    to_cnt_q <= to_inc;
                    // The lock sample that leaves WAIT_LOCK counts as the first stable one.
                    if (lock_s) begin
                        st_q       <= StStable;
                        stab_cnt_q <= STAB_W'(1);
                    end else if (timeout) begin
                        retry_cnt_q <= retry_inc;
                        if (give_up) begin
                            st_q      <= StFail;
                            pll_rst_q <= 1'b0;
                            fail_q    <= 1'b1;
                        end else begin
                            st_q      <= StPllRst;
                            pll_rst_q <= 1'b1;
                            rst_cnt_q <= '0;
                        end
                    end
                end

                StStable: begin
                    to_cnt_q <= to_inc;
                    if (lock_s && stab_done) begin
                        st_q        <= StRun;
                        rst_out_n_q <= 1'b1;
                        locked_q    <= 1'b1;
                        retry_cnt_q <= 4'd0;
                        stab_cnt_q  <= '0;
                    end else if (timeout) begin
                        stab_cnt_q  <= '0;
                        retry_cnt_q <= retry_inc;
                        if (give_up) begin
                            st_q      <= StFail;
                            pll_rst_q <= 1'b0;
                            fail_q    <= 1'b1;
                        end else begin
                            st_q      <= StPllRst;
                            pll_rst_q <= 1'b1;
                            rst_cnt_q <= '0;
                        end
                    end else if (!lock_s) begin
                        // Glitch: restart the stable count, keep the timeout running.
                        st_q       <= StWaitLock;
                        stab_cnt_q <= '0;
                    end else begin
                        stab_cnt_q <= stab_inc;
                    end
                end

                StRun: begin
                    if (!lock_s) begin
                        st_q        <= StPllRst;
                        pll_rst_q   <= 1'b1;
                        rst_out_n_q <= 1'b0;
                        locked_q    <= 1'b0;
                        rst_cnt_q   <= '0;
                        loss_cnt_q  <= loss_inc;
                    end
                end

                StFail: begin
                    if (retry_req) begin
                        st_q        <= StPllRst;
                        pll_rst_q   <= 1'b1;
                        fail_q      <= 1'b0;
                        retry_cnt_q <= 4'd0;
                        rst_cnt_q   <= '0;
                    end
                end

                default: begin
                    // Unreachable encodings recover through a fresh PLL reset.
                    st_q        <= StPllRst;
                    pll_rst_q   <= 1'b1;
                    rst_out_n_q <= 1'b0;
                    locked_q    <= 1'b0;
                    fail_q      <= 1'b0;
                    rst_cnt_q   <= '0;
                    to_cnt_q    <= '0;
                    stab_cnt_q  <= '0;
                end
            endcase
        end
    end

    assign pll_rst   = pll_rst_q;
    assign rst_out_n = rst_out_n_q;
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;
    assign loss_cnt  = loss_cnt_q;
    assign state     = st_q;

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_rst_ctrl
// Directed bench for pll_lock_rst_ctrl with small parameters
// (PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, RETRY_MAX=3, CNT_W=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_pll_lock_rst_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       pll_lock;
    logic       retry_req;
    logic       pll_rst;
    logic       rst_out_n;
    logic       locked;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_checks;
    int n_errors;
    int n_miss;
    bit ok;

    pll_lock_rst_ctrl #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (100),
        .STABLE_CYCLES  (8),
        .RETRY_MAX      (3),
        .CNT_W          (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pll_lock  (pll_lock),
        .retry_req (retry_req),
        .pll_rst   (pll_rst),
        .rst_out_n (rst_out_n),
        .locked    (locked),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt),
        .state     (state)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_locked(input int max_cycles, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (locked) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_miss    = 0;
        sys_rst_n = 1'b0;
        pll_lock  = 1'b0;
        retry_req = 1'b0;

        // Reset state
        tickn(2);
        check("rst_state", state, 0);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_rst_out_n", rst_out_n, 0);
        check("rst_locked", locked, 0);
        check("rst_fail", fail, 0);
        check("rst_retry_cnt", retry_cnt, 0);
        check("rst_loss_cnt", loss_cnt, 0);

        // 1: nominal bring-up, 4-cycle pll_rst pulse
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tickn(3);
        check("nom_pll_rst_hi", pll_rst, 1);
        check("nom_state_rst", state, 0);
        tick();
        check("nom_pll_rst_lo", pll_rst, 0);
        check("nom_state_wait", state, 1);
        tickn(20);
        check("nom_still_wait", state, 1);
        pll_lock = 1'b1;
        tickn(9);
        check("nom_pre_run_state", state, 2);
        check("nom_pre_run_rst_out_n", rst_out_n, 0);
        tick();
        check("nom_run_state", state, 3);
        check("nom_run_rst_out_n", rst_out_n, 1);
        check("nom_run_locked", locked, 1);
        check("nom_run_retry_cnt", retry_cnt, 0);

        // 4: lock loss in RUN, reset drops 2+1 edges later
        pll_lock = 1'b0;
        tickn(2);
        check("loss_pre_state", state, 3);
        check("loss_pre_rst_out_n", rst_out_n, 1);
        tick();
        check("loss_state", state, 0);
        check("loss_rst_out_n", rst_out_n, 0);
        check("loss_locked", locked, 0);
        check("loss_pll_rst", pll_rst, 1);
        check("loss_cnt_1", loss_cnt, 1);
        tickn(4);
        check("loss_wait_state", state, 1);
        check("loss_pll_rst_lo", pll_rst, 0);

        // 2: glitch during STABLE restarts the stable count, no pll_rst pulse
        pll_lock = 1'b1;       // E0
        tickn(5);              // E5
        pll_lock = 1'b0;
        tick();                // E6
        pll_lock = 1'b1;
        tick();                // E7
        check("gl_stable_e7", state, 2);
        tick();                // E8
        check("gl_wait_e8", state, 1);
        check("gl_no_pll_rst", pll_rst, 0);
        tick();                // E9
        check("gl_stable_e9", state, 2);
        tickn(6);              // E15
        check("gl_pre_run", state, 2);
        check("gl_pre_run_locked", locked, 0);
        tick();                // E16
        check("gl_run_state", state, 3);
        check("gl_run_locked", locked, 1);

        // 3: timeout retries then FAIL
        pll_lock = 1'b0;
        tickn(3);              // L
        check("to_loss_state", state, 0);
        check("to_loss_cnt_2", loss_cnt, 2);
        tickn(3);
        check("to_pulse1_hi", pll_rst, 1);
        tick();                // L+4
        check("to_pulse1_lo", pll_rst, 0);
        tickn(99);             // L+103
        check("to_wait_99", state, 1);
        check("to_retry_0", retry_cnt, 0);
        tick();                // L+104
        check("to_retry1_state", state, 0);
        check("to_retry_1", retry_cnt, 1);
        check("to_pulse2_hi", pll_rst, 1);
        tickn(4);              // L+108
        check("to_pulse2_lo", pll_rst, 0);
        tickn(100);            // L+208
        check("to_retry_2", retry_cnt, 2);
        check("to_pulse3_hi", pll_rst, 1);
        tickn(4);              // L+212
        check("to_pulse3_lo", pll_rst, 0);
        tickn(99);             // L+311
        check("to_pre_fail_state", state, 1);
        check("to_pre_fail_flag", fail, 0);
        tick();                // L+312
        check("to_fail_state", state, 4);
        check("to_fail_flag", fail, 1);
        check("to_fail_pll_rst", pll_rst, 0);
        check("to_fail_rst_out_n", rst_out_n, 0);
        check("to_retry_3", retry_cnt, 3);

        // Lock rising in FAIL is ignored
        pll_lock = 1'b1;
        tickn(10);
        check("fail_lock_ignored", state, 4);
        pll_lock = 1'b0;
        tickn(3);

        // retry_req restarts
        retry_req = 1'b1;
        tick();                // R
        retry_req = 1'b0;
        check("retry_state", state, 0);
        check("retry_cnt_clr", retry_cnt, 0);
        check("retry_pll_rst", pll_rst, 1);
        check("retry_fail_clr", fail, 0);

        // 5a: lock_s high on the timeout cycle -> STABLE, no retry
        tickn(101);            // R+101
        pll_lock = 1'b1;
        tickn(2);              // R+103
        check("c5a_wait", state, 1);
        tick();                // R+104
        check("c5a_stable", state, 2);
        check("c5a_no_retry", retry_cnt, 0);
        check("c5a_no_pll_rst", pll_rst, 0);
        tick();                // R+105: timer already expired, stable incomplete
        check("c5a_timeout_state", state, 0);
        check("c5a_timeout_retry", retry_cnt, 1);

        // 5b: stable completes on the timeout cycle -> RUN
        pll_lock = 1'b0;       // F
        tickn(94);             // F+94
        pll_lock = 1'b1;
        tickn(9);              // F+103
        check("c5b_pre", state, 2);
        tick();                // F+104
        check("c5b_run", state, 3);
        check("c5b_locked", locked, 1);
        check("c5b_retry_clr", retry_cnt, 0);

        // 5c: retry_req in RUN ignored
        retry_req = 1'b1;
        tick();
        retry_req = 1'b0;
        tickn(2);
        check("c5c_state", state, 3);
        check("c5c_locked", locked, 1);

        // 4b: repeated lock loss saturates loss_cnt
        for (int k = 0; k < 260; k++) begin
            pll_lock = 1'b0;
            tickn(3);
            pll_lock = 1'b1;
            wait_locked(40, ok);
            if (!ok) n_miss++;
        end
        check("sat_relock_misses", n_miss, 0);
        check("sat_loss_cnt", loss_cnt, 255);
        check("sat_locked", locked, 1);

        // 6: async reset mid-cycle in RUN
        #8;
        sys_rst_n = 1'b0;
        #1;
        check("ar_rst_out_n", rst_out_n, 0);
        check("ar_pll_rst", pll_rst, 1);
        check("ar_state", state, 0);
        check("ar_locked", locked, 0);
        check("ar_loss_cnt", loss_cnt, 0);
        check("ar_retry_cnt", retry_cnt, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tickn(4);
        check("ar_restart_wait", state, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
